// File: rtl/stack_seq.sv
// Multi-register PUSH/POP sequencer: walks a register mask, moves words between the register file and memory, and updates SP.
// Optional build macro STACK_SEQ_ALIGN_CHECK_EN rejects a misaligned sp_in with a fault before any memory access.
module stack_seq #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_pop,
    input  logic [7:0]  reg_list,
    input  logic        extra,
    input  logic [31:0] sp_in,
    input  logic [31:0] lr_in,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_rd,
    output logic [3:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        ld_pc,
    output logic [31:0] pc_wdata,
    output logic        ld_sp,
    output logic [31:0] sp_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WRSP, FIN} state_t;

    state_t      state, state_nx;

    logic        is_pop_q;
    logic [8:0]  rem_mask_q;   // bit 8 is the LR/PC slot so it naturally sorts last
    logic [31:0] sp_q;
    logic [31:0] lr_q;
    logic [3:0]  count_q;
    logic [31:0] addr_q;
    logic        mem_req_q;
    logic [7:0]  wait_cnt_q;
    logic        fault_q;
    logic        ld_rd_q;
    logic [3:0]  rd_addr_q;
    logic [31:0] rd_wdata_q;
    logic        ld_pc_q;
    logic [31:0] pc_wdata_q;
    logic        ld_sp_q;
    logic [31:0] sp_wdata_q;

    logic [3:0]  count_c;
    logic [3:0]  cur_idx;
    logic        last_xfer;
    logic        ack_hit;
    logic        timeout_hit;
    logic        align_err;
    logic [31:0] stride_c;
    logic [31:0] stride_q;

    function automatic logic [3:0] popcount9(input logic [8:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'd0, m[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [8:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[3:0];
            end
        end
        return idx;
    endfunction

    assign count_c   = popcount9(rem_mask_q);
    assign cur_idx   = lowest_idx(rem_mask_q);
    assign last_xfer = ((rem_mask_q & (rem_mask_q - 9'd1)) == 9'd0);
    assign stride_c  = {26'd0, count_c, 2'b00};
    assign stride_q  = {26'd0, count_q, 2'b00};
    assign ack_hit   = (state == XFER) && mem_req_q && mem_ack;

    // The wait counter holds the number of un-acked cycles already spent, so
    // the TIMEOUT-th empty cycle is the one that gives up.
    assign timeout_hit = (TIMEOUT != 8'd0) && (state == XFER) && mem_req_q &&
                         !mem_ack && (wait_cnt_q == TIMEOUT - 8'd1);

`ifdef STACK_SEQ_ALIGN_CHECK_EN
    assign align_err = (sp_q[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (align_err) begin
                    state_nx = IDLE;
                end else if (count_c != 4'd0) begin
                    state_nx = XFER;
                end else begin
                    state_nx = FIN;
                end
            end
            XFER: begin
                if (ack_hit && last_xfer) begin
                    state_nx = WRSP;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            WRSP:    state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_pop_q   <= 1'b0;
            rem_mask_q <= 9'd0;
            sp_q       <= 32'd0;
            lr_q       <= 32'd0;
            count_q    <= 4'd0;
            addr_q     <= 32'd0;
            mem_req_q  <= 1'b0;
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
            ld_rd_q    <= 1'b0;
            rd_addr_q  <= 4'd0;
            rd_wdata_q <= 32'd0;
            ld_pc_q    <= 1'b0;
            pc_wdata_q <= 32'd0;
            ld_sp_q    <= 1'b0;
            sp_wdata_q <= 32'd0;
        end else begin
            fault_q <= 1'b0;
            ld_rd_q <= 1'b0;
            ld_pc_q <= 1'b0;
            ld_sp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_pop_q   <= is_pop;
                        rem_mask_q <= {extra, reg_list};
                        sp_q       <= sp_in;
                        lr_q       <= lr_in;
                    end
                end
                SETUP: begin
                    count_q    <= count_c;
                    addr_q     <= is_pop_q ? sp_q : (sp_q - stride_c);
                    wait_cnt_q <= 8'd0;
                    if (!align_err && (count_c != 4'd0)) begin
                        mem_req_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (mem_req_q) begin
                        if (mem_ack) begin
                            mem_req_q  <= 1'b0;
                            wait_cnt_q <= 8'd0;
                            addr_q     <= addr_q + 32'd4;
                            rem_mask_q <= rem_mask_q & ~(9'd1 << cur_idx);
                            if (is_pop_q) begin
                                if (cur_idx[3]) begin
                                    ld_pc_q    <= 1'b1;
                                    pc_wdata_q <= mem_rdata & 32'hFFFF_FFFE;
                                end else begin
                                    ld_rd_q    <= 1'b1;
                                    rd_addr_q  <= {1'b0, cur_idx[2:0]};
                                    rd_wdata_q <= mem_rdata;
                                end
                            end
                            if (last_xfer) begin
                                ld_sp_q    <= 1'b1;
                                sp_wdata_q <= is_pop_q ? (sp_q + stride_q) : (sp_q - stride_q);
                            end
                        end else if (timeout_hit) begin
                            mem_req_q  <= 1'b0;
                            wait_cnt_q <= 8'd0;
                            fault_q    <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 8'd1;
                        end
                    end else begin
                        // one idle cycle between transfers, then request the next word
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign fault     = fault_q | ((state == SETUP) && align_err);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & ~is_pop_q;
    assign mem_addr  = mem_req_q ? addr_q : 32'd0;
    assign rs_addr   = ((state == XFER) && !is_pop_q && !cur_idx[3]) ? {1'b0, cur_idx[2:0]} : 4'd0;
    assign mem_wdata = (mem_req_q && !is_pop_q) ? (cur_idx[3] ? lr_q : rs_data) : 32'd0;
    assign ld_rd     = ld_rd_q;
    assign rd_addr   = rd_addr_q;
    assign rd_wdata  = rd_wdata_q;
    assign ld_pc     = ld_pc_q;
    assign pc_wdata  = pc_wdata_q;
    assign ld_sp     = ld_sp_q;
    assign sp_wdata  = sp_wdata_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: PUSH, POP, empty list, ack timeout, reset mid-POP, misaligned SP.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_pop, extra;
    logic [7:0]  reg_list;
    logic [31:0] sp_in, lr_in;
    logic [3:0]  rs_addr;
    logic [31:0] rs_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ld_rd, ld_pc, ld_sp, busy, done, fault;
    logic [3:0]  rd_addr;
    logic [31:0] rd_wdata, pc_wdata, sp_wdata;
    logic        ack_en;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_seq #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
        .extra(extra), .sp_in(sp_in), .lr_in(lr_in), .rs_addr(rs_addr), .rs_data(rs_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_rd(ld_rd), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .ld_pc(ld_pc), .pc_wdata(pc_wdata), .ld_sp(ld_sp),
        .sp_wdata(sp_wdata), .busy(busy), .done(done), .fault(fault)
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        case (a)
            32'h2000_00F4: return 32'h0000_0011;
            32'h2000_00F8: return 32'h0000_0077;
            32'h2000_00FC: return 32'h0000_0401;
            default:       return 32'h0BAD_0000;
        endcase
    endfunction

    assign mem_ack   = ack_en & mem_req;
    assign rs_data   = 32'hA000_0000 | {28'd0, rs_addr};
    assign mem_rdata = rdata_of(mem_addr);

    // Event log, sampled on the falling edge
    int          wr_n = 0, rd_n = 0, pc_n = 0, sp_n = 0, done_n = 0, fault_n = 0, req_cyc = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic        wr_we   [64];
    logic [3:0]  rda     [64];
    logic [31:0] rdd     [64];
    logic [31:0] pc_last = 32'd0, sp_last = 32'd0;

    always @(negedge clk) begin
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && mem_ack) begin
            wr_addr[wr_n] <= mem_addr;
            wr_data[wr_n] <= mem_wdata;
            wr_we[wr_n]   <= mem_we;
            wr_n          <= wr_n + 1;
        end
        if (ld_rd) begin
            rda[rd_n] <= rd_addr;
            rdd[rd_n] <= rd_wdata;
            rd_n      <= rd_n + 1;
        end
        if (ld_pc) begin
            pc_last <= pc_wdata;
            pc_n    <= pc_n + 1;
        end
        if (ld_sp) begin
            sp_last <= sp_wdata;
            sp_n    <= sp_n + 1;
        end
        if (done)  done_n  <= done_n + 1;
        if (fault) fault_n <= fault_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic pop, input logic [7:0] rl, input logic ex,
                            input logic [31:0] sp, input logic [31:0] lr);
        is_pop = pop; reg_list = rl; extra = ex; sp_in = sp; lr_in = lr;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cyc(1);
            k++;
        end
        check("idle_bound", {31'd0, busy}, 32'd0);
        cyc(1);
    endtask

    int b_wr, b_rd, b_pc, b_sp, b_done, b_fault, b_req;

    task automatic snap();
        b_wr = wr_n; b_rd = rd_n; b_pc = pc_n; b_sp = sp_n;
        b_done = done_n; b_fault = fault_n; b_req = req_cyc;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_pop = 1'b0; extra = 1'b0; reg_list = 8'd0;
        sp_in = 32'd0; lr_in = 32'd0; ack_en = 1'b1;
        #1;
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_ctrl",  {26'd0, done, fault, mem_req, ld_rd, ld_pc, ld_sp}, 32'd0);
        check("rst_addr",  mem_addr,  32'd0);
        check("rst_spw",   sp_wdata,  32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // PUSH R0-R3 + LR
        snap();
        start_op(1'b0, 8'h0F, 1'b1, 32'h2000_0100, 32'hCAFE_0014);
        wait_idle(60);
        check("push_nwr", wr_n - b_wr, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("push_addr", wr_addr[b_wr + i], 32'h2000_00EC + 32'(4 * i));
            check("push_data", wr_data[b_wr + i], (i < 4) ? (32'hA000_0000 + 32'(i)) : 32'hCAFE_0014);
            check("push_we",   {31'd0, wr_we[b_wr + i]}, 32'd1);
        end
        check("push_reqcyc", req_cyc - b_req, 32'd5);
        check("push_nsp",  sp_n - b_sp, 32'd1);
        check("push_sp",   sp_last, 32'h2000_00EC);
        check("push_done", done_n - b_done, 32'd1);
        check("push_nrd",  rd_n - b_rd, 32'd0);
        check("push_busy", {31'd0, busy}, 32'd0);

        // POP R0, R7 + PC
        snap();
        start_op(1'b1, 8'h81, 1'b1, 32'h2000_00F4, 32'd0);
        wait_idle(60);
        check("pop_nrd",  rd_n - b_rd, 32'd2);
        check("pop_r0a",  {28'd0, rda[b_rd]}, 32'd0);
        check("pop_r0d",  rdd[b_rd], 32'h0000_0011);
        check("pop_r7a",  {28'd0, rda[b_rd + 1]}, 32'd7);
        check("pop_r7d",  rdd[b_rd + 1], 32'h0000_0077);
        check("pop_npc",  pc_n - b_pc, 32'd1);
        check("pop_pc",   pc_last, 32'h0000_0400);
        check("pop_sp",   sp_last, 32'h2000_0100);
        check("pop_nwr",  wr_n - b_wr, 32'd3);
        check("pop_we",   {31'd0, wr_we[b_wr] | wr_we[b_wr + 1] | wr_we[b_wr + 2]}, 32'd0);
        check("pop_addr", wr_addr[b_wr + 2], 32'h2000_00FC);
        check("pop_done", done_n - b_done, 32'd1);

        // Empty list: done two cycles after start, no memory, no SP update
        snap();
        start_op(1'b0, 8'h00, 1'b0, 32'h1000_0000, 32'd0);
        check("empty_busy1", {31'd0, busy}, 32'd1);
        check("empty_done1", {31'd0, done}, 32'd0);
        cyc(1);
        check("empty_done2", {31'd0, done}, 32'd1);
        cyc(1);
        check("empty_done3", {31'd0, done}, 32'd0);
        check("empty_busy3", {31'd0, busy}, 32'd0);
        check("empty_req",   req_cyc - b_req, 32'd0);
        check("empty_nsp",   sp_n - b_sp, 32'd0);

        // Ack never arrives: fault after 4 request cycles
        ack_en = 1'b0;
        snap();
        start_op(1'b0, 8'h01, 1'b0, 32'h2000_0100, 32'd0);
        wait_idle(40);
        check("to_reqcyc", req_cyc - b_req, 32'd4);
        check("to_fault",  fault_n - b_fault, 32'd1);
        check("to_done",   done_n - b_done, 32'd0);
        check("to_nsp",    sp_n - b_sp, 32'd0);
        check("to_req",    {31'd0, mem_req}, 32'd0);
        ack_en = 1'b1;
        snap();
        start_op(1'b0, 8'h02, 1'b0, 32'h3000_0000, 32'd0);
        wait_idle(40);
        check("after_nwr",  wr_n - b_wr, 32'd1);
        check("after_addr", wr_addr[b_wr], 32'h2FFF_FFFC);
        check("after_data", wr_data[b_wr], 32'hA000_0001);
        check("after_sp",   sp_last, 32'h2FFF_FFFC);
        check("after_done", done_n - b_done, 32'd1);

        // Reset during the second POP transfer
        snap();
        begin
            int k;
            bit found;
            k = 0;
            found = 1'b0;
            start_op(1'b1, 8'h81, 1'b1, 32'h2000_00F4, 32'd0);
            while (!found && k < 40) begin
                if (mem_req && mem_addr == 32'h2000_00F8) found = 1'b1;
                else begin
                    cyc(1);
                    k++;
                end
            end
            check("rstx_found", {31'd0, found}, 32'd1);
        end
        rst = 1'b1;
        #1;
        check("rstx_req",  {31'd0, mem_req}, 32'd0);
        check("rstx_busy", {31'd0, busy}, 32'd0);
        check("rstx_addr", mem_addr, 32'd0);
        check("rstx_ld",   {29'd0, ld_rd, ld_pc, ld_sp}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("rstx_nrd",  rd_n - b_rd, 32'd1);
        check("rstx_r0",   rdd[b_rd], 32'h0000_0011);
        check("rstx_npc",  pc_n - b_pc, 32'd0);
        check("rstx_nsp",  sp_n - b_sp, 32'd0);
        check("rstx_done", done_n - b_done, 32'd0);

        // Misaligned SP
        snap();
        start_op(1'b0, 8'h01, 1'b0, 32'h2000_0102, 32'd0);
        wait_idle(40);
`ifdef STACK_SEQ_ALIGN_CHECK_EN
        check("algn_fault", fault_n - b_fault, 32'd1);
        check("algn_req",   req_cyc - b_req, 32'd0);
        check("algn_done",  done_n - b_done, 32'd0);
        check("algn_nsp",   sp_n - b_sp, 32'd0);
`else
        check("algn_nwr",   wr_n - b_wr, 32'd1);
        check("algn_addr",  wr_addr[b_wr], 32'h2000_00FE);
        check("algn_sp",    sp_last, 32'h2000_00FE);
        check("algn_done",  done_n - b_done, 32'd1);
        check("algn_fault", fault_n - b_fault, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
